game_text_buffer: RTL and testbench
===================================

# game_text_buffer

Parametrised, writable character buffer for on-screen game text. It replaces the fixed per-screen text ROMs with a RAM that game logic writes at run time. A built-in clear engine blanks the buffer, and a typewriter reveal engine unmasks characters one by one on a pacing tick. It sits between game control logic (write/command side) and the character renderer (read side). The read path keeps the established contract: address `{row, col}` in, registered char code out one cycle later.

## Interface
Parameters:
- `COLS`, 16: characters per row.
- `ROWS`, 8: number of rows.
- `CODE_W`, 7: char code width; must match `vga_pkg` codes.
- Derived: `COL_W = $clog2(COLS)`, `ROW_W = $clog2(ROWS)`, `DEPTH = ROWS*COLS`, `IDX_W = $clog2(DEPTH+1)`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `char_xy`, in, ROW_W+COL_W: read address, `{row, col}`.
- `char_code`, out, CODE_W: registered read data.
- `wr_en`, in, 1: write strobe.
- `wr_xy`, in, ROW_W+COL_W: write address, `{row, col}`.
- `wr_code`, in, CODE_W: write data.
- `clr_start`, in, 1: pulse; start a clear.
- `reveal_start`, in, 1: pulse; start a typewriter reveal.
- `tick`, in, 1: reveal pacing pulse, e.g. once per frame.
- `busy`, out, 1: a clear is in progress.
- `reveal_done`, out, 1: idle with every character visible.

## Operation
- Linear index is `idx = row*COLS + col`. An address with `row >= ROWS` or `col >= COLS` is out of range.
- FSM states are IDLE, CLEAR and REVEAL.
- **Reset:** FSM goes to CLEAR with `clr_cnt = 0` and `reveal_cnt = DEPTH`. The buffer therefore self-blanks after reset.
- **CLEAR:**
  - Writes SPACE to `clr_cnt` each cycle, then increments `clr_cnt`.
  - At `clr_cnt == DEPTH-1` the final write occurs, and the FSM goes to IDLE next cycle.
  - `wr_en`, `reveal_start`, `clr_start` and `tick` are ignored.
  - Reads return SPACE.
- **IDLE:**
  - `clr_start` goes to CLEAR with `clr_cnt = 0` and `reveal_cnt = DEPTH`.
  - Otherwise `reveal_start` goes to REVEAL with `reveal_cnt = 0`.
- **REVEAL:**
  - Each `tick` increments `reveal_cnt`. On the tick that makes it `DEPTH`, the FSM goes to IDLE.
  - `reveal_start` restarts with `reveal_cnt = 0`; it wins over a simultaneous `tick`.
  - `clr_start` aborts the reveal and goes to CLEAR with `reveal_cnt = DEPTH`; it wins over `reveal_start`.
- **Writes:**
  - Accepted in IDLE and REVEAL when `wr_en` is high and the address is in range.
  - Out-of-range writes are dropped.
- **Reads:**
  - `char_code` is SPACE if the address is out of range, the FSM is in CLEAR, or `idx >= reveal_cnt`.
  - Otherwise `char_code` is the stored code.
- **Flags:**
  - `busy` = (state == CLEAR).
  - `reveal_done` = (state == IDLE) && (`reveal_cnt == DEPTH`).

## Timing
- Read latency is 1 cycle: `char_xy` sampled at edge N appears on `char_code` after edge N.
- Masking uses the state and `reveal_cnt` values sampled at the same edge N as the address.
- Read and write to the same address in the same cycle is read-first: the old data is returned, and the new data is visible from the next read.
- A clear takes exactly DEPTH cycles with `busy` high; `busy` falls on the edge after the last write.
- A `clr_start` or `reveal_start` pulse takes effect on the next edge.
- Reset values:
  - `char_code` = 0.
  - `busy` = 1 (clear pending).
  - `reveal_done` = 0.
- A reset asserted mid-clear or mid-reveal restarts the clear from index 0.
- `tick` is a single-cycle pulse; a held `tick` advances `reveal_cnt` once per cycle.
- Reveal length is exactly DEPTH ticks.

## Structure
- The `SPACE` code and other char codes come from `vga_pkg`.
- Add to `vga_pkg`: typedef enum `text_buf_state_t` {TXT_IDLE, TXT_CLEAR, TXT_REVEAL}.
- Sub-module `game_text_ram`:
  - DEPTH×CODE_W array with one write port and a synchronous read, read-first.
  - Infers distributed or block RAM.
- Top level holds the FSM, `clr_cnt` and `reveal_cnt`, the write mux (clear engine vs. user port), and the output masking and register.

## Test plan
- **Reset and clear:** assert `rst` 1 cycle.
  - `busy` stays high exactly 128 cycles (16×8), then falls.
  - Reading all addresses returns SPACE, and `reveal_done` = 1.
- **Write/read:** write A to `{3,5}`, then read `{3,5}` next cycle → A one cycle later. Same-cycle read of `{3,5}` during the write → old SPACE.
- **Reveal:** fill the buffer with distinct codes, pulse `reveal_start`, issue 20 ticks.
  - idx 0..19 read back their stored codes; idx 20 reads SPACE.
  - After 128 ticks `reveal_done` = 1.
- **Priority:** in REVEAL, assert `clr_start` and `reveal_start` together → CLEAR entered, `busy` = 1. `wr_en` during the clear has no effect; the buffer is all SPACE afterwards.
- **Out of range:** with COLS = 12, write `{0,13}` → dropped; read `{0,13}` → SPACE.
- **Reset mid-clear:** at clear cycle 60, assert `rst` → `busy` stays high another full 128 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared character codes and text-buffer state encoding used by the VGA text
// path and the game text buffer.
package vga_pkg;

   localparam int VGA_CODE_W = 7;

   localparam logic [VGA_CODE_W-1:0] SPACE  = 7'h20;
   localparam logic [VGA_CODE_W-1:0] CHAR_0 = 7'h30;
   localparam logic [VGA_CODE_W-1:0] CHAR_A = 7'h41;

   typedef enum logic [1:0] {
      TXT_IDLE,
      TXT_CLEAR,
      TXT_REVEAL
   } text_buf_state_t;

endpackage

// File: rtl/game_text_ram.sv
// Single write port, synchronous read-first character storage for the game
// text buffer; written so synthesis can map it to distributed or block RAM.
module game_text_ram #(
   parameter int DEPTH  = 128,
   parameter int CODE_W = 7,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [CODE_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [CODE_W-1:0] rdata
);

   logic [CODE_W-1:0] mem [DEPTH];

   // Read and write share one clock edge; the read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/game_text_buffer.sv
// Run-time writable on-screen text buffer with a self-clearing engine and a
// tick-paced typewriter reveal; read port is {row, col} in, code out 1 cycle later.
module game_text_buffer
   import vga_pkg::*;
#(
   parameter int    COLS   = 16,
   parameter int    ROWS   = 8,
   parameter int    CODE_W = 7,
   localparam int   COL_W  = $clog2(COLS),
   localparam int   ROW_W  = $clog2(ROWS),
   localparam int   DEPTH  = ROWS * COLS,
   localparam int   IDX_W  = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ROW_W+COL_W-1:0] char_xy,
   output logic [CODE_W-1:0]      char_code,
   input  logic                   wr_en,
   input  logic [ROW_W+COL_W-1:0] wr_xy,
   input  logic [CODE_W-1:0]      wr_code,
   input  logic                   clr_start,
   input  logic                   reveal_start,
   input  logic                   tick,
   output logic                   busy,
   output logic                   reveal_done
);

   localparam int ADDR_W = $clog2(DEPTH);

   text_buf_state_t   state;
   logic [IDX_W-1:0]  clr_cnt;
   logic [IDX_W-1:0]  reveal_cnt;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [CODE_W-1:0] ram_wdata;
   logic [ADDR_W-1:0] ram_raddr_p0;
   logic [CODE_W-1:0] ram_q_p1;
   logic              vld_p1;
   logic              zero_p1;

   function automatic logic in_range(input logic [ROW_W+COL_W-1:0] xy);
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      row = xy[ROW_W+COL_W-1:COL_W];
      col = xy[COL_W-1:0];
      return (int'(row) < ROWS) && (int'(col) < COLS);
   endfunction

   function automatic logic [IDX_W-1:0] to_idx(input logic [ROW_W+COL_W-1:0] xy);
      logic [ROW_W-1:0] row;
      logic [COL_W-1:0] col;
      row = xy[ROW_W+COL_W-1:COL_W];
      col = xy[COL_W-1:0];
      return IDX_W'(int'(row) * COLS + int'(col));
   endfunction

   // Control FSM; busy and reveal_done are updated together with each transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= TXT_CLEAR;
         clr_cnt     <= '0;
         reveal_cnt  <= IDX_W'(DEPTH);
         busy        <= 1'b1;
         reveal_done <= 1'b0;
      end else begin
         case (state)
            TXT_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                  state       <= TXT_IDLE;
                  busy        <= 1'b0;
                  reveal_done <= 1'b1;
               end
            end
            TXT_IDLE: begin
               if (clr_start) begin
                  state       <= TXT_CLEAR;
                  clr_cnt     <= '0;
                  reveal_cnt  <= IDX_W'(DEPTH);
                  busy        <= 1'b1;
                  reveal_done <= 1'b0;
               end else if (reveal_start) begin
                  state       <= TXT_REVEAL;
                  reveal_cnt  <= '0;
                  reveal_done <= 1'b0;
               end
            end
            TXT_REVEAL: begin
               if (clr_start) begin
                  state       <= TXT_CLEAR;
                  clr_cnt     <= '0;
                  reveal_cnt  <= IDX_W'(DEPTH);
                  busy        <= 1'b1;
               end else if (reveal_start) begin
                  reveal_cnt <= '0;
               end else if (tick) begin
                  reveal_cnt <= reveal_cnt + 1'b1;
                  if (reveal_cnt == IDX_W'(DEPTH - 1)) begin
                     state       <= TXT_IDLE;
                     reveal_done <= 1'b1;
                  end
               end
            end
            default: begin
               state       <= TXT_CLEAR;
               clr_cnt     <= '0;
               reveal_cnt  <= IDX_W'(DEPTH);
               busy        <= 1'b1;
               reveal_done <= 1'b0;
            end
         endcase
      end
   end

   // The clear engine owns the write port while clearing; user writes otherwise.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = ADDR_W'(to_idx(wr_xy));
      ram_wdata = wr_code;
      if (state == TXT_CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = ADDR_W'(clr_cnt);
         ram_wdata = CODE_W'(SPACE);
      end else if (wr_en && in_range(wr_xy)) begin
         ram_we = 1'b1;
      end
   end

   assign ram_raddr_p0 = in_range(char_xy) ? ADDR_W'(to_idx(char_xy)) : '0;

   game_text_ram #(
      .DEPTH  (DEPTH),
      .CODE_W (CODE_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr_p0),
      .rdata (ram_q_p1)
   );

   // p0 -> p1: mask decision captured on the same edge as the RAM read.
   always_ff @(posedge clk) begin
      zero_p1 <= rst;
      vld_p1  <= in_range(char_xy) && (state != TXT_CLEAR) &&
                 (to_idx(char_xy) < reveal_cnt);
   end

   assign char_code = zero_p1 ? '0 : (vld_p1 ? ram_q_p1 : CODE_W'(SPACE));

endmodule

// File: tb/tb_game_text_buffer.sv
// Randomized scoreboard bench for game_text_buffer, using a non-power-of-two
// geometry so both row and column out-of-range addresses are exercised.
module tb_game_text_buffer;

   localparam int COLS  = 12;
   localparam int ROWS  = 6;
   localparam int CW    = 7;
   localparam int XYW   = 7;
   localparam int DEPTH = COLS * ROWS;
   localparam logic [CW-1:0] SP = 7'h20;

   logic           clk = 1'b0;
   logic           rst;
   logic [XYW-1:0] char_xy;
   logic [CW-1:0]  char_code;
   logic           wr_en;
   logic [XYW-1:0] wr_xy;
   logic [CW-1:0]  wr_code;
   logic           clr_start;
   logic           reveal_start;
   logic           tick;
   logic           busy;
   logic           reveal_done;

   always #5 clk = ~clk;

   game_text_buffer #(.COLS(COLS), .ROWS(ROWS), .CODE_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .char_xy      (char_xy),
      .char_code    (char_code),
      .wr_en        (wr_en),
      .wr_xy        (wr_xy),
      .wr_code      (wr_code),
      .clr_start    (clr_start),
      .reveal_start (reveal_start),
      .tick         (tick),
      .busy         (busy),
      .reveal_done  (reveal_done)
   );

   typedef struct {
      logic [CW-1:0] code;
      logic          busy;
      logic          done;
      int            cyc;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // Reference model: mode 0 = idle, 1 = clearing, 2 = revealing.
   int            m_mode = 1;
   int            m_cpos = 0;
   int            m_rev  = DEPTH;
   logic [CW-1:0] m_mem [DEPTH];

   function automatic bit in_rng(input logic [XYW-1:0] xy);
      return (int'(xy[6:4]) < ROWS) && (int'(xy[3:0]) < COLS);
   endfunction

   function automatic int lin(input logic [XYW-1:0] xy);
      return int'(xy[6:4]) * COLS + int'(xy[3:0]);
   endfunction

   function automatic logic [XYW-1:0] xy_of(input int idx);
      logic [2:0] r;
      logic [3:0] c;
      r = 3'(idx / COLS);
      c = 4'(idx % COLS);
      return {r, c};
   endfunction

   task automatic check(input string nm, input logic [CW-1:0] act,
                        input logic [CW-1:0] want, input int at);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h expected=%h", nm, at, act, want);
      end
   endtask

   // Predict this edge's outputs from the current inputs, advance the model, clock.
   task automatic step();
      exp_t e;
      if (rst)
         e.code = '0;
      else if (!in_rng(char_xy) || m_mode == 1 || lin(char_xy) >= m_rev)
         e.code = SP;
      else
         e.code = m_mem[lin(char_xy)];

      if (rst) begin
         m_mode = 1; m_cpos = 0; m_rev = DEPTH;
      end else if (m_mode == 1) begin
         m_mem[m_cpos] = SP;
         if (m_cpos == DEPTH - 1) m_mode = 0;
         m_cpos++;
      end else begin
         if (wr_en && in_rng(wr_xy)) m_mem[lin(wr_xy)] = wr_code;
         if (clr_start) begin
            m_mode = 1; m_cpos = 0; m_rev = DEPTH;
         end else if (reveal_start) begin
            m_mode = 2; m_rev = 0;
         end else if (m_mode == 2 && tick) begin
            m_rev++;
            if (m_rev == DEPTH) m_mode = 0;
         end
      end
      e.busy = (m_mode == 1);
      e.done = (m_mode == 0) && (m_rev == DEPTH);
      e.cyc  = cyc;
      sbq.push_back(e);

      @(posedge clk);
      #3;
      cyc++;
      rst = 0; wr_en = 0; clr_start = 0; reveal_start = 0; tick = 0;
   endtask

   task automatic rand_read();
      char_xy = XYW'($urandom);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check("char_code", char_code, mon_e.code, mon_e.cyc);
            check("busy", CW'(busy), CW'(mon_e.busy), mon_e.cyc);
            check("reveal_done", CW'(reveal_done), CW'(mon_e.done), mon_e.cyc);
         end
      end
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = SP;
      rst = 1; wr_en = 0; wr_xy = '0; wr_code = '0; char_xy = '0;
      clr_start = 0; reveal_start = 0; tick = 0;
      step();

      // Power-on clear with noise on every ignored input.
      for (int i = 0; i < DEPTH + 4; i++) begin
         rand_read();
         if (i < DEPTH - 2) begin
            wr_en = 1'($urandom); wr_xy = XYW'($urandom); wr_code = CW'($urandom);
            tick = 1'($urandom);
         end
         step();
      end
      for (int a = 0; a < 128; a++) begin char_xy = XYW'(a); step(); end

      // Write A to {3,5} with a same-cycle read, then read it back.
      wr_en = 1; wr_xy = {3'd3, 4'd5}; wr_code = 7'h41; char_xy = {3'd3, 4'd5};
      step();
      char_xy = {3'd3, 4'd5}; step();
      step();

      // Fill with distinct codes, then reveal 20 characters.
      for (int i = 0; i < DEPTH; i++) begin
         wr_en = 1; wr_xy = xy_of(i); wr_code = CW'(33 + i); rand_read(); step();
      end
      reveal_start = 1; step();
      for (int i = 0; i < 20; i++) begin tick = 1; rand_read(); step(); end
      for (int i = 0; i < 22; i++) begin char_xy = xy_of(i); step(); end
      for (int i = 0; i < 3 * DEPTH && m_mode == 2; i++) begin
         tick = 1'($urandom); rand_read(); step();
      end
      for (int i = 0; i < 4; i++) begin rand_read(); step(); end

      // clr_start beats reveal_start and tick; writes during the clear are ignored.
      reveal_start = 1; step();
      for (int i = 0; i < 5; i++) begin tick = 1; char_xy = xy_of(i); step(); end
      clr_start = 1; reveal_start = 1; tick = 1; step();
      for (int i = 0; i < DEPTH + 2; i++) begin
         wr_en = 1; wr_xy = XYW'($urandom); wr_code = CW'($urandom); rand_read(); step();
      end
      for (int a = 0; a < 128; a++) begin char_xy = XYW'(a); step(); end

      // Out-of-range writes must not alias onto in-range cells.
      wr_en = 1; wr_xy = {3'd0, 4'd13}; wr_code = 7'h55; step();
      wr_en = 1; wr_xy = {3'd6, 4'd2};  wr_code = 7'h56; step();
      wr_en = 1; wr_xy = {3'd7, 4'd15}; wr_code = 7'h57; step();
      char_xy = {3'd0, 4'd13}; step();
      char_xy = {3'd1, 4'd1};  step();
      char_xy = {3'd0, 4'd1};  step();
      char_xy = {3'd6, 4'd2};  step();
      char_xy = {3'd0, 4'd2};  step();
      char_xy = {3'd3, 4'd15}; step();

      // Mixed random traffic.
      for (int i = 0; i < 900; i++) begin
         wr_en        = ($urandom_range(2) == 0);
         wr_xy        = XYW'($urandom);
         wr_code      = CW'($urandom);
         clr_start    = ($urandom_range(199) == 0);
         reveal_start = ($urandom_range(59) == 0);
         tick         = ($urandom_range(1) == 0);
         rst          = ($urandom_range(499) == 0);
         rand_read();
         step();
      end

      // Reset landing 60 cycles into a clear restarts it from index 0.
      for (int i = 0; i < 3; i++) begin wr_en = 1; wr_xy = xy_of(i); wr_code = 7'h41; step(); end
      clr_start = 1; step();
      for (int i = 0; i < 60; i++) begin rand_read(); step(); end
      rst = 1; step();
      for (int i = 0; i < DEPTH + 4; i++) begin rand_read(); step(); end

      @(posedge clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected=0", sbq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
